fdiv_sign_exp_round: RTL and testbench
======================================

// Module: fdiv_sign_exp_round
// PURPOSE
//  Wraps the 10-stage fdiv_mantissa divider into a full IEEE-754 single fdiv.
//  - Front: unpacks a/b and drives the mantissa operands into the mantissa divider.
//  - Side path: carries sign, exponent and special-case info through a delay line of the same length.
//  - Back: normalises and rounds the 26-bit quotient, then registers the packed result.
//  - Fully pipelined: accepts one operation per cycle, no stalls.
// PARAMETERS
//  MANT_LAT  10  cycles from mant_in_valid to mant_out_valid (must equal divider depth)
//  QNAN      32'h7FC0_0000  canonical NaN result
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   async active-low reset
//  in_valid       in   1   operand pair valid this cycle
//  a              in   32  dividend (IEEE single)
//  b              in   32  divisor (IEEE single)
//  mant_in_valid  out  1   = in_valid (combinational)
//  mant_dividend  out  24  {1'b1,a[22:0]} (combinational)
//  mant_divisor   out  24  {1'b1,b[22:0]} (combinational)
//  mant_quotient  in   26  divider quotient, Q[25] weight 2^0
//  mant_out_valid in   1   divider output valid
//  result_valid   out  1   result valid (1-cycle pulse per op)
//  result         out  32  packed quotient
//  flag_ovf       out  1   overflow to inf
//  flag_unf       out  1   underflow flushed to zero
//  flag_dz        out  1   finite nonzero / zero
//  flag_inv       out  1   invalid (NaN input, 0/0, inf/inf)
//  align_err      out  1   sticky: side-path valid != mant_out_valid
// BEHAVIOUR
//  Reset: all outputs, all delay-line entries and align_err go to 0 immediately.
//  Latency: result_valid occurs MANT_LAT+1 = 11 cycles after in_valid; results stay in input order.
//  Throughput: back-to-back inputs are allowed, with no bubbles required.
//  Input classification (denormals are flushed):
//   - exp==0 -> zero.
//   - exp==255 with frac==0 -> inf.
//   - exp==255 with frac!=0 -> NaN.
//  Side-path capture on in_valid: sign = a[31]^b[31]; e = ea - eb + 127, as a 10-bit signed value.
//  Special cases (priority order), then the 3-bit flag set:
//   - NaN in, 0/0, inf/inf -> QNAN, inv.
//   - x/0 (x finite nonzero) -> {sign,8'hFF,23'h0}, dz.
//   - inf/x -> signed inf (no flags).
//   - 0/x or x/inf -> signed zero (no flags).
//  Side-path delay line: MANT_LAT stages holding valid, sign, e, special code and flags.
//   - The last stage is used together with mant_quotient.
//  Normalise, Q = mant_quotient:
//   - Q[25]=1 -> m = Q[25:2], guard g = Q[1], E = e.
//   - Q[25]=0 -> m = Q[24:1], g = Q[0], E = e-1.
//  Round: m' = m + g (round-half-up; no sticky bit is available).
//   - If m' carries out (0x1000000): m' = 0x800000 and E += 1.
//  Range checks, applied after rounding:
//   - E >= 255 -> signed inf, ovf.
//   - E <= 0 -> signed zero, unf.
//   - Otherwise {sign, E[7:0], m'[22:0]}.
//  Output register: result and flags update only when the side-path valid is high.
//   - They hold their value otherwise.
//   - result_valid = side-path valid, registered.
//  Special results ignore mant_quotient but still take the full 11-cycle latency.
//  Alignment check: if the last-stage side-path valid != mant_out_valid on any cycle, set align_err.
//   - align_err stays set until reset.
//   - The side-path valid still governs result_valid.
//  Reset mid-operation: in-flight ops are discarded and no result_valid is produced for them.
//   - The first input after reset release returns 11 cycles later.
// TESTING
//  1 a=40C00000 (6.0), b=40000000 (2.0) -> result=40400000 at +11 cycles, no flags.
//  2 a=3F800000 (1.0), b=40400000 (3.0) -> result=3EAAAAAB (round-up via guard bit).
//  3 a=3F800000, b=00000000 -> 7F800000, flag_dz=1.
//    a=00000000, b=00000000 -> 7FC00000, flag_inv=1.
//  4 Range extremes:
//    a=7F000000, b=3E800000 -> 7F800000, flag_ovf=1.
//    a=00800000, b=4B000000 -> 00000000, flag_unf=1.
//  5 20 back-to-back random finite pairs -> 20 consecutive results in order.
//    Each matches a round-half-up reference model; align_err stays 0.
//  6 rst_n low at cycle 5 after three issued ops -> no result_valid pulses from them, outputs 0.
//    Next op issued after release arrives at exactly +11.

Source files
------------

// File: rtl/fdiv_sign_exp_round_if.sv
// Operand/result bundle of the single-precision divide wrapper.
// master = operation issuer, slave = fdiv_sign_exp_round.
interface fdiv_sign_exp_round_if;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        result_valid;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_dz;
    logic        flag_inv;
    logic        align_err;

    modport master (
        output in_valid, a, b,
        input  result_valid, result, flag_ovf, flag_unf, flag_dz, flag_inv, align_err
    );

    modport slave (
        input  in_valid, a, b,
        output result_valid, result, flag_ovf, flag_unf, flag_dz, flag_inv, align_err
    );
endinterface

// File: rtl/fdiv_sign_exp_round.sv
// IEEE-754 single divide wrapper around an external MANT_LAT-deep mantissa divider.
// Sign, exponent and special-case info ride a matching delay line; the back end normalises, rounds and packs.
module fdiv_sign_exp_round #(
    parameter int          MANT_LAT = 10,
    parameter logic [31:0] QNAN     = 32'h7FC0_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fdiv_sign_exp_round_if.slave   bus,
    output logic                   mant_in_valid,
    output logic [23:0]            mant_dividend,
    output logic [23:0]            mant_divisor,
    input  logic [25:0]            mant_quotient,
    input  logic                   mant_out_valid
);
    localparam int LAST = MANT_LAT - 1;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_QNAN = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } spec_e;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } pack_t;

    // Round-half-up on the guard bit; bit 24 of the result is the carry-out.
    function automatic logic [24:0] round_half_up(input logic [23:0] m, input logic g);
        return {1'b0, m} + {24'd0, g};
    endfunction

    // Saturate the biased exponent into inf / flushed zero, otherwise pack normally.
    function automatic pack_t saturate_pack(input logic s, input logic signed [9:0] e,
                                            input logic [22:0] frac);
        pack_t p;
        p.ovf = 1'b0;
        p.unf = 1'b0;
        if (e >= 10'sd255) begin
            p.res = {s, 8'hFF, 23'd0};
            p.ovf = 1'b1;
        end else if (e <= 10'sd0) begin
            p.res = {s, 31'd0};
            p.unf = 1'b1;
        end else begin
            p.res = {s, e[7:0], frac};
        end
        return p;
    endfunction

    // ---- stage p0: unpack and classify operands
    logic [7:0]         ea, eb;
    logic               a_zero, a_inf, a_nan;
    logic               b_zero, b_inf, b_nan;
    logic               sign_p0;
    logic signed [9:0]  e_p0;
    spec_e              spec_p0;
    logic               inv_p0, dz_p0;

    assign mant_in_valid = bus.in_valid;
    assign mant_dividend = {1'b1, bus.a[22:0]};
    assign mant_divisor  = {1'b1, bus.b[22:0]};

    assign ea     = bus.a[30:23];
    assign eb     = bus.b[30:23];
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (bus.a[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (bus.b[22:0] == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (bus.a[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (bus.b[22:0] != 23'd0);

    assign sign_p0 = bus.a[31] ^ bus.b[31];
    assign e_p0    = signed'({2'b00, ea}) - signed'({2'b00, eb}) + 10'sd127;

    always_comb begin
        spec_p0 = SP_NONE;
        inv_p0  = 1'b0;
        dz_p0   = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_p0 = SP_QNAN;
            inv_p0  = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_p0 = SP_INF;
            dz_p0   = 1'b1;
        end else if (a_inf) begin
            spec_p0 = SP_INF;
        end else if (a_zero || b_inf) begin
            spec_p0 = SP_ZERO;
        end
    end

    // ---- side-path delay line, same depth as the mantissa divider
    logic               side_vld_p  [MANT_LAT];
    logic               side_sign_p [MANT_LAT];
    logic signed [9:0]  side_e_p    [MANT_LAT];
    spec_e              side_spec_p [MANT_LAT];
    logic               side_inv_p  [MANT_LAT];
    logic               side_dz_p   [MANT_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MANT_LAT; i++) begin
                side_vld_p[i]  <= 1'b0;
                side_sign_p[i] <= 1'b0;
                side_e_p[i]    <= 10'sd0;
                side_spec_p[i] <= SP_NONE;
                side_inv_p[i]  <= 1'b0;
                side_dz_p[i]   <= 1'b0;
            end
        end else begin
            side_vld_p[0]  <= bus.in_valid;
            side_sign_p[0] <= sign_p0;
            side_e_p[0]    <= e_p0;
            side_spec_p[0] <= spec_p0;
            side_inv_p[0]  <= inv_p0;
            side_dz_p[0]   <= dz_p0;
            for (int i = 1; i < MANT_LAT; i++) begin
                side_vld_p[i]  <= side_vld_p[i-1];
                side_sign_p[i] <= side_sign_p[i-1];
                side_e_p[i]    <= side_e_p[i-1];
                side_spec_p[i] <= side_spec_p[i-1];
                side_inv_p[i]  <= side_inv_p[i-1];
                side_dz_p[i]   <= side_dz_p[i-1];
            end
        end
    end

    // ---- back end: normalise, round, range-check, special override
    logic               q_hi;
    logic [23:0]        m_n;
    logic               g_n;
    logic signed [9:0]  e_n;
    logic [24:0]        m_r;
    logic [22:0]        frac_fin;
    logic signed [9:0]  e_fin;
    pack_t              pk;
    logic [31:0]        res_d;
    logic               ovf_d, unf_d;

    always_comb begin
        q_hi = mant_quotient[25];
        m_n  = q_hi ? mant_quotient[25:2] : mant_quotient[24:1];
        g_n  = q_hi ? mant_quotient[1]    : mant_quotient[0];
        e_n  = q_hi ? side_e_p[LAST]      : side_e_p[LAST] - 10'sd1;
        m_r  = round_half_up(m_n, g_n);
        if (m_r[24]) begin
            frac_fin = 23'd0;
            e_fin    = e_n + 10'sd1;
        end else begin
            frac_fin = m_r[22:0];
            e_fin    = e_n;
        end
        pk = saturate_pack(side_sign_p[LAST], e_fin, frac_fin);
    end

    always_comb begin
        res_d = pk.res;
        ovf_d = pk.ovf;
        unf_d = pk.unf;
        case (side_spec_p[LAST])
            SP_QNAN: begin
                res_d = QNAN;
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            SP_INF: begin
                res_d = {side_sign_p[LAST], 8'hFF, 23'd0};
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            SP_ZERO: begin
                res_d = {side_sign_p[LAST], 31'd0};
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            default: ;
        endcase
    end

    // ---- output register; result/flags hold between valid results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result_valid <= 1'b0;
            bus.result       <= 32'd0;
            bus.flag_ovf     <= 1'b0;
            bus.flag_unf     <= 1'b0;
            bus.flag_dz      <= 1'b0;
            bus.flag_inv     <= 1'b0;
            bus.align_err    <= 1'b0;
        end else begin
            bus.result_valid <= side_vld_p[LAST];
            if (side_vld_p[LAST]) begin
                bus.result   <= res_d;
                bus.flag_ovf <= ovf_d;
                bus.flag_unf <= unf_d;
                bus.flag_dz  <= side_dz_p[LAST];
                bus.flag_inv <= side_inv_p[LAST];
            end
            if (side_vld_p[LAST] != mant_out_valid) begin
                bus.align_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fdiv_sign_exp_round.sv
// Bench for fdiv_sign_exp_round: behavioural 10-stage mantissa divider, directed vector table,
// forced-quotient rounding corners, random back-to-back stream, alignment and mid-flight reset.
`timescale 1ns/1ps
module tb_fdiv_sign_exp_round;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fdiv_sign_exp_round_if bus();
    logic        mant_in_valid;
    logic [23:0] mant_dividend;
    logic [23:0] mant_divisor;
    logic [25:0] mant_quotient;
    logic        mant_out_valid;

    fdiv_sign_exp_round dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .mant_in_valid  (mant_in_valid),
        .mant_dividend  (mant_dividend),
        .mant_divisor   (mant_divisor),
        .mant_quotient  (mant_quotient),
        .mant_out_valid (mant_out_valid)
    );

    // Behavioural mantissa divider: Q = floor(n * 2^25 / d), ten register stages.
    logic        dv_vld [10];
    logic [25:0] dv_q   [10];
    logic        force_q_en = 1'b0;
    logic [25:0] force_q    = 26'd0;
    logic        glitch     = 1'b0;

    function automatic logic [25:0] div_q(input logic [23:0] n, input logic [23:0] d);
        logic [63:0] w;
        w = ({40'd0, n} << 25) / {40'd0, d};
        return w[25:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) begin
                dv_vld[i] <= 1'b0;
                dv_q[i]   <= 26'd0;
            end
        end else begin
            dv_vld[0] <= mant_in_valid;
            dv_q[0]   <= force_q_en ? force_q : div_q(mant_dividend, mant_divisor);
            for (int i = 1; i < 10; i++) begin
                dv_vld[i] <= dv_vld[i-1];
                dv_q[i]   <= dv_q[i-1];
            end
        end
    end
    assign mant_quotient  = dv_q[9];
    assign mant_out_valid = dv_vld[9] | glitch;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          issue;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;   // {ovf, unf, dz, inv}
    } vec_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Scoreboard: every result_valid pulse must match the oldest outstanding operation.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (bus.result_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result_valid got=%h want=none", bus.result);
            end else begin
                mon_e = sbq.pop_front();
                check("result", bus.result, mon_e.res);
                check("flags", {28'd0, bus.flag_ovf, bus.flag_unf, bus.flag_dz, bus.flag_inv},
                      {28'd0, mon_e.flg});
                check("latency", 32'(cyc - mon_e.issue), 32'd11);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic [3:0] flg, input bit push);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        if (push) begin
            e.res   = res;
            e.flg   = flg;
            e.issue = cyc;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d_pending want=0", sbq.size());
            sbq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_valid"}, {31'd0, bus.result_valid}, 32'd0);
        check({nm, "_result"}, bus.result, 32'd0);
        check({nm, "_flags"}, {28'd0, bus.flag_ovf, bus.flag_unf, bus.flag_dz, bus.flag_inv}, 32'd0);
        check({nm, "_align"}, {31'd0, bus.align_err}, 32'd0);
    endtask

    // Reference for finite normal operands: wide quotient, add half an ulp, truncate.
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        int          sh;
        logic [63:0] q;
        logic [63:0] r;
        logic [31:0] res;
        logic [3:0]  f;
        s = a[31] ^ b[31];
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        q = ({40'd0, 1'b1, a[22:0]} << 40) / {40'd0, 1'b1, b[22:0]};
        if (q[40]) begin
            sh = 17;
        end else begin
            sh = 16;
            e  = e - 1;
        end
        r = (q + (64'd1 << (sh - 1))) >> sh;
        if (r[24]) begin
            r = 64'h80_0000;
            e = e + 1;
        end
        f = 4'b0000;
        if (e >= 255) begin
            res = {s, 8'hFF, 23'd0};
            f   = 4'b1000;
        end else if (e <= 0) begin
            res = {s, 31'd0};
            f   = 4'b0100;
        end else begin
            res = {s, 8'(e), r[22:0]};
        end
        return {f, res};
    endfunction

    vec_t vt [20];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [35:0] rr;

        vt[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000};
        vt[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000};
        vt[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010};
        vt[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001};
        vt[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000};
        vt[5]  = '{32'h00800000, 32'h4B000000, 32'h00000000, 4'b0100};
        vt[6]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001};
        vt[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0001};
        vt[8]  = '{32'h3F800000, 32'hFFC00000, 32'h7FC00000, 4'b0001};
        vt[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vt[10] = '{32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000};
        vt[11] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000};
        vt[12] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0010};
        vt[13] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000};
        vt[14] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000};
        vt[15] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
        vt[16] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
        vt[17] = '{32'h00800000, 32'h3F800001, 32'h00000000, 4'b0100};
        vt[18] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000};
        vt[19] = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b1000};

        bus.in_valid = 1'b0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        idle(2);

        // Single isolated operation, then the whole table back-to-back.
        issue(vt[0].a, vt[0].b, vt[0].res, vt[0].flg, 1'b1);
        drain();
        for (int i = 0; i < 20; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].res, vt[i].flg, 1'b1);
        end
        drain();

        // Forced quotients reaching the rounding carry-out on both normalisation paths.
        force_q_en = 1'b1;
        force_q    = 26'h3FFFFFF;
        issue(32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b1);
        issue(32'h7F000000, 32'h3F800000, 32'h7F800000, 4'b1000, 1'b1);
        force_q    = 26'h1FFFFFF;
        issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 1'b1);
        force_q_en = 1'b0;
        drain();

        // Random finite operands, back-to-back.
        for (int i = 0; i < 20; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
            rr = ref_div(ra, rb);
            issue(ra, rb, rr[31:0], rr[35:32], 1'b1);
        end
        drain();
        check("align_after_stream", {31'd0, bus.align_err}, 32'd0);

        // Alignment error: divider valid without a matching side-path valid.
        glitch = 1'b1;
        @(posedge clk); #1;
        glitch = 1'b0;
        check("align_set", {31'd0, bus.align_err}, 32'd1);
        idle(3);
        check("align_sticky", {31'd0, bus.align_err}, 32'd1);

        // Reset with three operations in flight; they must never emerge.
        issue(32'h40C00000, 32'h40000000, 32'h0, 4'b0, 1'b0);
        issue(32'h3F800000, 32'h40400000, 32'h0, 4'b0, 1'b0);
        issue(32'h3F800000, 32'h00000000, 32'h0, 4'b0, 1'b0);
        idle(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        idle(2);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
        drain();
        idle(12);
        check("align_after_reset", {31'd0, bus.align_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
